// File: rtl/logic_unit_pkg.sv
// Shared definitions for the multi-cycle bitwise logic unit.
// Op-codes and FSM state encoding.
package logic_unit_pkg;

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/logic_slice.sv
// Combinational SLICE-bit bitwise operator.
// One instance serves every slice of the operand.
module logic_slice
  import logic_unit_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [2:0]       op,
  output logic [SLICE-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      default: y = a;
    endcase
  end

endmodule

// File: rtl/logic_unit_n_bits.sv
// WIDTH-bit bitwise logic unit computing SLICE bits per clock,
// with valid/ready on both sides and a zero flag.
module logic_unit_n_bits
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] SMASK = WIDTH'({SLICE{1'b1}});

  if ((WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("logic_unit_n_bits: WIDTH must be a multiple of SLICE");
  end

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  logic [31:0]      w_base;
  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic [SLICE-1:0] w_y;
  logic [WIDTH-1:0] w_y_wide;
  logic [WIDTH-1:0] w_mask;

  // Shifts instead of part-selects keep the slice index width-agnostic.
  assign w_base   = 32'(r_cnt) * 32'(SLICE);
  assign w_a_sh   = r_a >> w_base;
  assign w_b_sh   = r_b >> w_base;
  assign w_y_wide = WIDTH'(w_y) << w_base;
  assign w_mask   = SMASK << w_base;

  logic_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a  (w_a_sh[SLICE-1:0]),
    .b  (w_b_sh[SLICE-1:0]),
    .op (r_op),
    .y  (w_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_NOT;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_cnt   <= '0;
            r_zero  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_result <= (r_result & ~w_mask) | w_y_wide;
          r_zero   <= r_zero & (w_y == '0);
          if (r_cnt == LAST) begin
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  // The accumulator is live during RUN; expose it only with the result.
  assign zero      = r_zero & (r_state == DONE);

endmodule
